led_pwm_fader: RTL and testbench
================================

// Module: led_pwm_fader
// PURPOSE
//   Downstream LED output stage. Takes the raw on/off LED pattern from the blinker
//   and drives each LED with PWM whose duty ramps toward the pattern, producing
//   fades instead of hard on/off steps. Sits between the pattern generator and
//   the board LED pins. All outputs are registered.
// PARAMETERS
//   OUT_WIDTH  8     number of LED channels
//   PWM_BITS   8     PWM counter/brightness width (>=2); MAX = 2**PWM_BITS-1
//   RAMP_DIV   1024  clock cycles per brightness step (>=1)
// PORTS
//   aclk       in   1          clock
//   arstn      in   1          asynchronous reset, active-low
//   enable     in   1          1 = run; 0 = outputs dark, brightness frozen
//   led_in     in   OUT_WIDTH  target pattern (1 = fade to full, 0 = fade to off)
//   led        out  OUT_WIDTH  PWM-modulated LED drive
//   pwm_wrap   out  1          one-cycle pulse when PWM counter wraps MAX->0
//   settled    out  1          1 = every channel at its target brightness
// BEHAVIOUR
//   Reset (arstn=0, async): pwm_cnt=0, prescaler=0, bright[i]=0, led=0,
//     pwm_wrap=0, settled=0. Release takes effect on the next aclk edge.
//   Prescaler: counts 0..RAMP_DIV-1 while enable=1; ramp_tick is high in the
//     cycle prescaler==RAMP_DIV-1, then prescaler wraps to 0. RAMP_DIV=1 -> tick
//     every cycle.
//   PWM counter: PWM_BITS wide, +1 each enabled cycle, wraps MAX->0.
//     pwm_wrap registered: high the cycle after pwm_cnt==MAX was sampled.
//   Brightness (per channel, updated only on ramp_tick edge):
//     led_in[i]=1 and bright[i]<MAX -> bright[i]+1; at MAX holds (saturate).
//     led_in[i]=0 and bright[i]>0   -> bright[i]-1; at 0 holds (saturate).
//     led_in changes mid-ramp reverse direction on the next tick; no reset of
//     bright. led_in sampled at the tick edge only.
//   Output compare (registered, 1-cycle latency from pwm_cnt/bright):
//     led[i] <= enable & ((bright[i]==MAX) | (bright[i] > pwm_cnt)).
//     bright=0 -> always 0; bright=MAX -> always 1; else duty bright/2**PWM_BITS.
//   settled (registered): 1 when for all i bright[i]==(led_in[i]?MAX:0).
//   enable=0: prescaler and pwm_cnt cleared to 0 synchronously, bright held,
//     led=0 and pwm_wrap=0 from the next edge; settled still evaluated.
//     enable 0->1 restarts the PWM period and ramp interval from 0.
//   Widths: prescaler $clog2(RAMP_DIV) bits (min 1); bright compare unsigned.
//   No combinational path input->output.
// TESTING  (bench: OUT_WIDTH=8, PWM_BITS=4, RAMP_DIV=2)
//   Reset hold, enable=1, led_in=8'hFF -> led=0, settled=0 during reset;
//     after release led stays 0 until bright[i]>0 (first tick at cycle 2).
//   led_in=8'h01 held 40 cycles -> bright[0] reaches 15 after 15 ticks (30
//     cycles), then led[0]=1 every cycle, led[7:1]=0, settled=1.
//   bright[0]=15, led_in 1->0 -> bright decrements 1 per 2 cycles to 0, saturates;
//     at bright=4 led[0] high exactly 4 of 16 cycles per PWM period.
//   Toggle led_in[0] at bright=7 (rising) -> next tick bright=6, no jump.
//   Free run -> pwm_wrap pulses every 16 cycles; deassert enable -> led=0,
//     pwm_wrap=0 next cycle, bright unchanged on re-enable.
//   arstn pulled low mid-ramp asynchronously -> all outputs 0 without clock edge.

Source files
------------

// File: rtl/led_pwm_fader.sv
// led_pwm_fader: per-channel PWM LED driver whose brightness ramps toward the target pattern.
module led_pwm_fader #(
  parameter int OUT_WIDTH = 8,
  parameter int PWM_BITS  = 8,
  parameter int RAMP_DIV  = 1024
) (
  input  logic                 aclk,
  input  logic                 arstn,
  input  logic                 enable,
  input  logic [OUT_WIDTH-1:0] led_in,
  output logic [OUT_WIDTH-1:0] led,
  output logic                 pwm_wrap,
  output logic                 settled
);
  localparam int PW = RAMP_DIV > 1 ? $clog2(RAMP_DIV) : 1;
  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PW-1:0] LAST = PW'(RAMP_DIV - 1);
  logic [PW-1:0] presc;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [OUT_WIDTH-1:0][PWM_BITS-1:0] bright, bright_nxt;
  logic [OUT_WIDTH-1:0] led_nxt, at_tgt;
  logic ramp_tick;
  assign ramp_tick = enable && presc == LAST;
  always_comb begin
    bright_nxt = bright;
    led_nxt = '0;
    at_tgt = '0;
    for (int i = 0; i < OUT_WIDTH; i++) begin
      if (ramp_tick)
        bright_nxt[i] = led_in[i] ? (bright[i] == MAX ? bright[i] : bright[i] + PWM_BITS'(1))
                                  : (bright[i] == '0 ? bright[i] : bright[i] - PWM_BITS'(1));
      led_nxt[i] = enable & ((bright[i] == MAX) | (bright[i] > pwm_cnt));
      at_tgt[i] = bright[i] == (led_in[i] ? MAX : '0);
    end
  end
  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      presc <= '0;
      pwm_cnt <= '0;
      bright <= '0;
      led <= '0;
      pwm_wrap <= 1'b0;
      settled <= 1'b0;
    end else begin
      presc <= (!enable || ramp_tick) ? '0 : presc + PW'(1);
      pwm_cnt <= enable ? pwm_cnt + PWM_BITS'(1) : '0;
      pwm_wrap <= enable && pwm_cnt == MAX;
      bright <= bright_nxt;
      led <= led_nxt;
      settled <= &at_tgt;
    end
  end
endmodule

// File: tb/tb_led_pwm_fader.sv
// tb_led_pwm_fader: directed checks of ramping, PWM compare, wrap pulse, enable and async reset.
module tb_led_pwm_fader;
  logic aclk = 1'b0, arstn = 1'b0, enable = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led;
  logic pwm_wrap, settled;
  int n_cmp = 0, n_bad = 0;

  led_pwm_fader #(.OUT_WIDTH(8), .PWM_BITS(4), .RAMP_DIV(2)) dut (
    .aclk(aclk), .arstn(arstn), .enable(enable), .led_in(led_in),
    .led(led), .pwm_wrap(pwm_wrap), .settled(settled)
  );

  always #5 aclk = ~aclk;

  task automatic step(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // After return the next rising edge is edge 1 after release.
  task automatic restart(input logic [7:0] pat);
    arstn = 1'b0; enable = 1'b1; led_in = pat;
    step(2);
    arstn = 1'b1;
  endtask

  task automatic test_reset;
    arstn = 1'b0; enable = 1'b1; led_in = 8'hFF;
    step(3);
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL reset_led got %h want 00", led); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL reset_settled got %b want 0", settled); end
    n_cmp++; if (pwm_wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap got %b want 0", pwm_wrap); end
    arstn = 1'b1;
    // bright(e)=floor((e-1)/2) never exceeds pwm_cnt=(e-1) until the counter wraps
    for (int e = 1; e <= 17; e++) begin
      step(1);
      n_cmp++;
      if (led !== (e == 17 ? 8'hFF : 8'h00)) begin
        n_bad++; $display("FAIL release_led edge %0d got %h want %h", e, led, (e == 17 ? 8'hFF : 8'h00));
      end
    end
  endtask

  task automatic test_ramp_up;
    restart(8'h01);
    step(30);
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL up_settled_e30 got %b want 0", settled); end
    step(1);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL up_settled_e31 got %b want 1", settled); end
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL up_led_e31 got %h want 01", led); end
    step(1);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL up_led_e32 got %h want 01", led); end
  endtask

  task automatic test_ramp_down;
    int highs;
    led_in = 8'h00;
    step(1);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL down_led_e33 got %h want 01", led); end
    step(1);
    n_cmp++; if (led !== 8'h01) begin n_bad++; $display("FAIL down_led_e34 got %h want 01", led); end
    step(14);
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL down_settled_e48 got %b want 0", settled); end
    // edges 49..64 span one PWM period while bright falls 7,7,6,6,5,5,4,4,...
    highs = 0;
    for (int e = 49; e <= 64; e++) begin
      step(1);
      highs += int'(led[0]);
      n_cmp++; if (led[7:1] !== 7'h00) begin n_bad++; $display("FAIL down_others edge %0d got %h want 00", e, led[7:1]); end
      if (e == 62) begin
        n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL down_settled_e62 got %b want 0", settled); end
      end
      if (e == 63) begin
        n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL down_settled_e63 got %b want 1", settled); end
      end
    end
    n_cmp++; if (highs !== 5) begin n_bad++; $display("FAIL down_duty got %0d want 5", highs); end
    highs = 0;
    for (int e = 65; e <= 80; e++) begin
      step(1);
      highs += int'(led[0]);
    end
    n_cmp++; if (highs !== 0) begin n_bad++; $display("FAIL down_saturate got %0d want 0", highs); end
  endtask

  task automatic test_reverse;
    logic [5:0] exp_bits;
    exp_bits = 6'b001111;
    restart(8'h01);
    step(14);
    led_in = 8'h00;
    step(2);
    // bright 7 -> 6 at edge 16, then 5, 4; pwm_cnt 0..5 over edges 17..22
    for (int e = 17; e <= 22; e++) begin
      step(1);
      n_cmp++;
      if (led[0] !== exp_bits[e-17]) begin
        n_bad++; $display("FAIL reverse_led edge %0d got %b want %b", e, led[0], exp_bits[e-17]);
      end
    end
  endtask

  task automatic test_wrap_enable;
    restart(8'hFF);
    for (int e = 1; e <= 47; e++) begin
      step(1);
      n_cmp++;
      if (pwm_wrap !== (e % 16 == 0)) begin
        n_bad++; $display("FAIL wrap edge %0d got %b want %b", e, pwm_wrap, (e % 16 == 0));
      end
    end
    n_cmp++; if (led !== 8'hFF) begin n_bad++; $display("FAIL full_led got %h want ff", led); end
    enable = 1'b0;
    step(1);
    n_cmp++; if (pwm_wrap !== 1'b0) begin n_bad++; $display("FAIL dis_wrap got %b want 0", pwm_wrap); end
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL dis_led got %h want 00", led); end
    step(4);
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL dis_led_hold got %h want 00", led); end
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL dis_settled got %b want 1", settled); end
    led_in = 8'h00;
    step(1);
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL dis_settled_tgt got %b want 0", settled); end
    led_in = 8'hFF;
    step(1);
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL dis_settled_back got %b want 1", settled); end
    enable = 1'b1;
    step(1);
    n_cmp++; if (led !== 8'hFF) begin n_bad++; $display("FAIL reen_led got %h want ff", led); end
    for (int k = 2; k <= 16; k++) begin
      step(1);
      n_cmp++;
      if (pwm_wrap !== (k == 16)) begin
        n_bad++; $display("FAIL reen_wrap cycle %0d got %b want %b", k, pwm_wrap, (k == 16));
      end
    end
  endtask

  task automatic test_async_reset;
    n_cmp++; if (settled !== 1'b1) begin n_bad++; $display("FAIL pre_rst_settled got %b want 1", settled); end
    #2 arstn = 1'b0;
    #1;
    n_cmp++; if (led !== 8'h00) begin n_bad++; $display("FAIL arst_led got %h want 00", led); end
    n_cmp++; if (pwm_wrap !== 1'b0) begin n_bad++; $display("FAIL arst_wrap got %b want 0", pwm_wrap); end
    n_cmp++; if (settled !== 1'b0) begin n_bad++; $display("FAIL arst_settled got %b want 0", settled); end
  endtask

  initial begin
    test_reset;
    test_ramp_up;
    test_ramp_down;
    test_reverse;
    test_wrap_enable;
    test_async_reset;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
